i2s_sample_packer: RTL and testbench
====================================

Name: i2s_sample_packer

Overview:
Sits between the I2S microphone receiver and the byte-wide sample FIFO inside the Rofofo capture path. It averages every REDUCE_FACTOR consecutive signed PCM samples into one sample (decimation). It then serialises that sample MSB-first into 8-bit FIFO writes, honouring FIFO backpressure. The I2S side cannot stall, so samples that cannot be emitted in time are dropped and counted.

Parameters:
DATA_SIZE, 24, width of the signed input sample; must be a multiple of 8, range 16..32.
REDUCE_FACTOR, 2, number of samples averaged per output sample; power of two, 1..16.
COMPRESS_OUT, 1, 1 = emit only the top 16 bits of each averaged sample (2 bytes); 0 = emit all DATA_SIZE/8 bytes.

Ports:
clk  input  1  system clock (100 MHz in the Kintex7 build).
rst_n  input  1  asynchronous active-low reset.
sample_valid  input  1  one-cycle strobe; sample_data is valid this cycle.
sample_data  input  DATA_SIZE  signed two's-complement PCM sample.
fifo_full  input  1  downstream FIFO cannot accept a write this cycle.
fifo_wr_en  output  1  write strobe to the FIFO.
fifo_wr_data  output  8  byte to write; valid while fifo_wr_en = 1.
busy  output  1  serializer holds a sample not yet fully written.
drop_count  output  16  number of averaged samples discarded; saturates at 0xFFFF.

Behaviour:
- Clock and reset: one clock, clk. Reset is rst_n, asynchronous and active-low.
- Reset values: accumulator = 0, sample counter = 0, state = IDLE, shift register = 0, byte index = 0, drop_count = 0, busy = 0, fifo_wr_en = 0, fifo_wr_data = 0x00.
- Accumulator:
  - Signed, width DATA_SIZE + log2(REDUCE_FACTOR).
  - Every sample_valid is accepted unconditionally. There is no input backpressure.
  - Each accepted sample is sign-extended and added to the accumulator; the counter increments.
- Average completion:
  - The average completes on the cycle the REDUCE_FACTOR-th sample is accepted.
  - avg = (acc + sample) >>> log2(REDUCE_FACTOR). This is an arithmetic shift, flooring toward -inf, truncated to DATA_SIZE bits.
  - Accumulator and counter clear on that same cycle.
  - REDUCE_FACTOR = 1 passes each sample straight through.
- Output word:
  - COMPRESS_OUT = 1: avg[DATA_SIZE-1 -: 16], NBYTES = 2.
  - COMPRESS_OUT = 0: the full avg, NBYTES = DATA_SIZE/8.
- Serializer FSM, states IDLE and SEND:
  - IDLE -> SEND when an average completes. The output word is loaded into the shift register and the byte index is set to 0.
  - In SEND: fifo_wr_en = !fifo_full. This is combinational from state and fifo_full, and is never asserted while fifo_full = 1.
  - fifo_wr_data is the current MSB byte of the registered shift register.
  - On each cycle with fifo_wr_en = 1: shift left by 8 and increment the byte index.
  - SEND -> IDLE after the write of byte NBYTES-1, unless a new load occurs on that cycle.
  - With fifo_full = 1 the state, byte and index hold unchanged.
- Load acceptance:
  - A completed average is loaded if state = IDLE.
  - It is also loaded if state = SEND and the last byte is being written this cycle. The FSM then stays in SEND with the new word and index 0, giving back-to-back output with no bubble.
  - Otherwise the new average is dropped: drop_count increments by 1 (saturating) and the in-flight word continues untouched.
- Latency: when the last contributing sample_valid is at cycle N, busy = 1 and the first fifo_wr_en (if not full) occur at cycle N+1. Without backpressure the last byte is at N+NBYTES.
- busy = (state == SEND).
- Reset mid-operation: all state clears immediately. Partial averages and unsent bytes are lost, and no further fifo_wr_en is issued.

Test Plan:
1. DATA_SIZE=24, RF=2, COMPRESS_OUT=0, fifo_full=0; inputs 0x000010, 0x000020 -> three consecutive writes 0x00, 0x00, 0x18 starting 1 cycle after the 2nd strobe; busy is high for exactly 3 cycles.
2. Same config; inputs 0xFFFFF0 (-16), 0xFFFFDF (-33) -> avg floor(-24.5) = -25 = 0xFFFFE7 -> writes 0xFF, 0xFF, 0xE7.
3. COMPRESS_OUT=1, RF=2; inputs 0x123456, 0x123458 -> avg 0x123457 -> exactly two writes 0x12, 0x34.
4. Backpressure: config 1; raise fifo_full for 5 cycles right after the first byte -> fifo_wr_en is 0 for those 5 cycles, the next byte is still 0x00, and the total write count is 3.
5. Drop/back-to-back:
   - RF=1, COMPRESS_OUT=0, fifo_full held 1; strobe 0x0A0B0C then 0x111111 -> drop_count = 1; after release the writes are 0x0A, 0x0B, 0x0C only.
   - A new sample strobed on the cycle the last byte writes -> its bytes follow with no idle cycle.
6. Reset: assert rst_n=0 after the first byte of a 3-byte word -> all outputs return to reset values at once, and no writes occur until new samples arrive after release.

Source files
------------

// File: rtl/i2s_sample_packer.sv
// i2s_sample_packer: average REDUCE_FACTOR PCM samples and serialise each result MSB-first into byte FIFO writes
module i2s_sample_packer #(
  parameter int DATA_SIZE     = 24,
  parameter int REDUCE_FACTOR = 2,
  parameter int COMPRESS_OUT  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sample_valid,
  input  logic [DATA_SIZE-1:0] sample_data,
  input  logic                 fifo_full,
  output logic                 fifo_wr_en,
  output logic [7:0]           fifo_wr_data,
  output logic                 busy,
  output logic [15:0]          drop_count
);
  localparam int LG = $clog2(REDUCE_FACTOR);
  localparam int AW = DATA_SIZE + LG;
  localparam int CW = LG > 0 ? LG : 1;
  localparam int NB = COMPRESS_OUT != 0 ? 2 : DATA_SIZE / 8;
  localparam int OW = NB * 8;
  localparam int IW = $clog2(NB);
  typedef enum logic {IDLE, SEND} state_t;
  state_t state, state_d;
  logic signed [AW-1:0] acc, sum;
  logic [CW-1:0] cnt;
  logic [OW-1:0] sr, word;
  logic [IW-1:0] idx;
  logic done, last, load;
  // the output word is the top OW bits of the floored average
  assign sum = acc + AW'($signed(sample_data));
  assign word = OW'((sum >>> LG) >> (DATA_SIZE - OW));
  assign done = sample_valid && cnt == CW'(REDUCE_FACTOR - 1);
  assign fifo_wr_en = state == SEND && !fifo_full;
  assign fifo_wr_data = sr[OW-1 -: 8];
  assign busy = state == SEND;
  assign last = fifo_wr_en && idx == IW'(NB - 1);
  assign load = done && (state == IDLE || last);
  always_comb begin
    state_d = state;
    state_d = load ? SEND : last ? IDLE : state;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_d;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      acc <= '0;
      cnt <= '0;
      sr <= '0;
      idx <= '0;
      drop_count <= '0;
    end else begin
      if (done) begin
        acc <= '0;
        cnt <= '0;
      end else if (sample_valid) begin
        acc <= sum;
        cnt <= cnt + 1'b1;
      end
      if (load) begin
        sr <= word;
        idx <= '0;
      end else if (fifo_wr_en) begin
        sr <= sr << 8;
        idx <= idx + 1'b1;
      end
      if (done && !load && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
    end
endmodule

// File: tb/tb_i2s_sample_packer.sv
// tb_i2s_sample_packer: three packer configurations driven in parallel and compared every cycle against a byte-stream model
module tb_i2s_sample_packer;
  logic clk, rst_n, sample_valid, fifo_full;
  logic [23:0] sample_data;
  logic wr_en[3], busy[3];
  logic [7:0] wr_data[3];
  logic [15:0] dc[3];
  int errors, checks;
  int rf[3] = '{2, 2, 1};
  int nb[3] = '{3, 2, 3};
  longint acc[3], pend[3];
  int cnt[3], rem[3], drops[3], ncap[3];
  logic [31:0] cap[3];
  int d0;

  i2s_sample_packer #(.DATA_SIZE(24), .REDUCE_FACTOR(2), .COMPRESS_OUT(0)) u_a (
    .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid), .sample_data(sample_data),
    .fifo_full(fifo_full), .fifo_wr_en(wr_en[0]), .fifo_wr_data(wr_data[0]),
    .busy(busy[0]), .drop_count(dc[0]));
  i2s_sample_packer #(.DATA_SIZE(24), .REDUCE_FACTOR(2), .COMPRESS_OUT(1)) u_b (
    .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid), .sample_data(sample_data),
    .fifo_full(fifo_full), .fifo_wr_en(wr_en[1]), .fifo_wr_data(wr_data[1]),
    .busy(busy[1]), .drop_count(dc[1]));
  i2s_sample_packer #(.DATA_SIZE(24), .REDUCE_FACTOR(1), .COMPRESS_OUT(0)) u_c (
    .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid), .sample_data(sample_data),
    .fifo_full(fifo_full), .fifo_wr_en(wr_en[2]), .fifo_wr_data(wr_data[2]),
    .busy(busy[2]), .drop_count(dc[2]));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr_cap();
    for (int i = 0; i < 3; i++) begin
      cap[i] = 0;
      ncap[i] = 0;
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 3; i++) begin
      acc[i] = 0; pend[i] = 0; cnt[i] = 0; rem[i] = 0; drops[i] = 0;
    end
  endtask

  task automatic do_reset();
    rst_n = 0; sample_valid = 0; fifo_full = 0; sample_data = 0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_wr_en%0d", i), 32'(wr_en[i]), 0);
      chk($sformatf("rst_data%0d", i), 32'(wr_data[i]), 0);
      chk($sformatf("rst_busy%0d", i), 32'(busy[i]), 0);
      chk($sformatf("rst_drop%0d", i), 32'(dc[i]), 0);
    end
    model_clear();
    @(posedge clk);
    #1 rst_n = 1;
  endtask

  // one clock cycle: drive, compare mid-cycle, then advance the model across the edge
  task automatic step(input logic v, input logic [23:0] d, input logic f);
    longint r, avg, w;
    sample_valid = v; sample_data = d; fifo_full = f;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("busy%0d", i), 32'(busy[i]), 32'(rem[i] > 0));
      chk($sformatf("wr_en%0d", i), 32'(wr_en[i]), 32'(rem[i] > 0 && !f));
      if (rem[i] > 0) chk($sformatf("data%0d", i), 32'(wr_data[i]), 32'((pend[i] >> (8 * (rem[i] - 1))) & 255));
      chk($sformatf("drop%0d", i), 32'(dc[i]), 32'(drops[i]));
      if (wr_en[i]) begin
        cap[i] = {cap[i][23:0], wr_data[i]};
        ncap[i]++;
      end
    end
    for (int i = 0; i < 3; i++) begin
      if (rem[i] > 0 && !f) rem[i]--;
      if (v) begin
        acc[i] += longint'($signed(d));
        cnt[i]++;
        if (cnt[i] == rf[i]) begin
          r = acc[i] % rf[i];
          if (r < 0) r += rf[i];
          avg = (acc[i] - r) / rf[i];
          w = avg & 64'hFFFFFF;
          if (nb[i] == 2) w = w >> 8;
          if (rem[i] == 0) begin
            pend[i] = w;
            rem[i] = nb[i];
          end else if (drops[i] < 65535) drops[i]++;
          acc[i] = 0;
          cnt[i] = 0;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    clk = 0; rst_n = 1; sample_valid = 0; fifo_full = 0; sample_data = 0;
    errors = 0; checks = 0;
    model_clear();
    clr_cap();
    #3;
    do_reset();
    repeat (2) step(0, 0, 0);
    // average of two small positives
    clr_cap();
    step(1, 24'h000010, 0);
    step(1, 24'h000020, 0);
    repeat (5) step(0, 0, 0);
    chk("p1_bytes", cap[0][23:0], 24'h000018);
    chk("p1_count", ncap[0], 3);
    // negative average floors toward -inf
    clr_cap();
    step(1, 24'hFFFFF0, 0);
    step(1, 24'hFFFFDF, 0);
    repeat (5) step(0, 0, 0);
    chk("p2_bytes", cap[0][23:0], 24'hFFFFE7);
    // compressed output keeps top 16 bits
    clr_cap();
    step(1, 24'h123456, 0);
    step(1, 24'h123458, 0);
    repeat (5) step(0, 0, 0);
    chk("p3_bytes", cap[1][15:0], 16'h1234);
    chk("p3_count", ncap[1], 2);
    // backpressure after the first byte
    clr_cap();
    step(1, 24'h000010, 0);
    step(1, 24'h000020, 0);
    step(0, 0, 0);
    repeat (5) step(0, 0, 1);
    repeat (5) step(0, 0, 0);
    chk("p4_bytes", cap[0][23:0], 24'h000018);
    chk("p4_count", ncap[0], 3);
    // drop while the FIFO is full
    d0 = dc[2];
    step(1, 24'h0A0B0C, 1);
    step(1, 24'h111111, 1);
    step(0, 0, 1);
    chk("p5_drop_delta", 32'(dc[2]) - d0, 1);
    clr_cap();
    repeat (5) step(0, 0, 0);
    chk("p5_bytes", cap[2][23:0], 24'h0A0B0C);
    chk("p5_count", ncap[2], 3);
    // back-to-back load on the last byte
    clr_cap();
    step(1, 24'hA1B2C3, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    step(1, 24'h445566, 0);
    repeat (5) step(0, 0, 0);
    chk("b2b_tail", cap[2], 32'hC3445566);
    chk("b2b_count", ncap[2], 6);
    // reset in the middle of a word
    clr_cap();
    step(1, 24'h000010, 0);
    step(1, 24'h000020, 0);
    step(0, 0, 0);
    do_reset();
    repeat (4) step(0, 0, 0);
    chk("rst_count", ncap[0], 1);
    // randomized traffic
    for (int n = 0; n < 500; n++)
      step($urandom % 3 == 0, 24'($urandom), $urandom % 4 == 0);
    repeat (6) step(0, 0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
